mem_arbiter: RTL

Arbiter and sequencer that shares one memory port between the processor's instruction-fetch path and its load/store data path. Each requester issues a held request. The block grants one requester, drives the shared memory port until the memory acknowledges or a timeout expires, and returns the read data with a one-cycle done pulse. It sits between the control unit's fetch/execute sequencing and the single memory model.

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one memory port between the instruction-fetch path
//                and the load/store data path. Grants one held request,
//                drives the memory port until m_ack or a timeout, then
//                returns read data with a one-cycle done pulse and err flag.
//  Option      : ARB_ROUND_ROBIN_EN - when defined, a tie in IDLE grants the
//                port opposite to the last owner; when undefined, the data
//                port always wins a tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction-fetch requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  // Load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  // Shared memory port
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  // Status
  output logic              err,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Counter is 8 bits wide; the compare uses one extra bit so the
  // increment never wraps before it is checked against the limit.
  localparam logic [8:0] c_timeout_lim = 9'(TIMEOUT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;
  logic [8:0]          w_cnt_inc;
  logic                w_timeout_hit;
  logic                w_any_req;
  logic                w_grant_data;

  logic                w_m_req_nxt;
  logic                w_m_we_nxt;
  logic [ADDR_W-1:0]   w_m_addr_nxt;
  logic [DATA_W-1:0]   w_m_wdata_nxt;
  logic [DATA_W-1:0]   w_i_rdata_nxt;
  logic [DATA_W-1:0]   w_d_rdata_nxt;
  logic                w_i_done_nxt;
  logic                w_d_done_nxt;
  logic                w_err_nxt;
  logic                w_busy_nxt;
  logic                w_owner_nxt;

  assign w_cnt_inc     = {1'b0, r_cnt} + 9'd1;
  assign w_timeout_hit = (w_cnt_inc >= c_timeout_lim);
  assign w_any_req     = i_req | d_req;

  // Grant decision: which requester wins if a grant happens this cycle.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, hand the port to whoever did not own it last.
    w_grant_data = d_req & (~i_req | ~owner);
`else
    // Data path has strict priority; fetch waits while d_req is held.
    w_grant_data = d_req;
`endif
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_m_req_nxt   = m_req;
    w_m_we_nxt    = m_we;
    w_m_addr_nxt  = m_addr;
    w_m_wdata_nxt = m_wdata;
    w_i_rdata_nxt = i_rdata;
    w_d_rdata_nxt = d_rdata;
    w_i_done_nxt  = 1'b0;
    w_d_done_nxt  = 1'b0;
    w_err_nxt     = err;
    w_busy_nxt    = busy;
    w_owner_nxt   = owner;

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_owner_nxt   = w_grant_data;
          w_m_req_nxt   = 1'b1;
          w_m_we_nxt    = w_grant_data & d_we;
          w_m_addr_nxt  = w_grant_data ? d_addr : i_addr;
          w_m_wdata_nxt = (w_grant_data & d_we) ? d_wdata : '0;
          w_cnt_nxt     = 8'd0;
          w_err_nxt     = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_ACCESS;
        end
      end

      S_ACCESS: begin
        w_cnt_nxt = w_cnt_inc[7:0];
        // An ack arriving on the timeout cycle still counts as success.
        if (m_ack) begin
          w_m_req_nxt = 1'b0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESP;
          if (owner) begin
            w_d_rdata_nxt = m_we ? '0 : m_rdata;
            w_d_done_nxt  = 1'b1;
          end else begin
            w_i_rdata_nxt = m_rdata;
            w_i_done_nxt  = 1'b1;
          end
        end else if (w_timeout_hit) begin
          w_m_req_nxt = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RESP;
          if (owner) begin
            w_d_rdata_nxt = '0;
            w_d_done_nxt  = 1'b1;
          end else begin
            w_i_rdata_nxt = '0;
            w_i_done_nxt  = 1'b1;
          end
        end
      end

      S_RESP: begin
        // Done pulse is visible during this cycle; clear status on exit.
        w_err_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_m_req_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter and output registers; reset drops the port at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      owner   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      m_req   <= w_m_req_nxt;
      m_we    <= w_m_we_nxt;
      m_addr  <= w_m_addr_nxt;
      m_wdata <= w_m_wdata_nxt;
      i_rdata <= w_i_rdata_nxt;
      d_rdata <= w_d_rdata_nxt;
      i_done  <= w_i_done_nxt;
      d_done  <= w_d_done_nxt;
      err     <= w_err_nxt;
      busy    <= w_busy_nxt;
      owner   <= w_owner_nxt;
    end
  end

endmodule
`default_nettype wire
